// File: rtl/btn_event_arbiter.sv
// Latches button press pulses as pending events and issues them one at a time
// over valid/ready, using a round-robin search and a saturating drop counter.
module btn_event_arbiter #(
  parameter int N_BTN  = 4,
  parameter int IDX_W  = 2,
  parameter int DROP_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_BTN-1:0]  btn_pulse_i,
  input  logic              evt_ready_i,
  output logic              evt_valid_o,
  output logic [IDX_W-1:0]  evt_idx_o,
  output logic [N_BTN-1:0]  pending_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  localparam int CNT_W = $clog2(N_BTN + 1);
  localparam int SUM_W = DROP_W + 6;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr;

  logic               found;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W:0]     probe;
  logic               fire;
  logic [N_BTN-1:0]   gnt_mask;
  logic [N_BTN-1:0]   drops;
  logic [CNT_W-1:0]   ndrop;
  logic [SUM_W-1:0]   drop_sum;
  logic [DROP_W-1:0]  drop_next;

  // First set pending bit at or above rr, wrapping modulo N_BTN.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    probe   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      probe = {1'b0, rr} + (IDX_W+1)'(i);
      if (probe >= (IDX_W+1)'(N_BTN))
        probe = probe - (IDX_W+1)'(N_BTN);
      if (!found && pending_o[probe[IDX_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = probe[IDX_W-1:0];
      end
    end
  end

  // A grant happens from IDLE, or from HOLD when the current event is accepted.
  assign fire     = found && ((state == IDLE) || evt_ready_i);
  assign gnt_mask = fire ? (N_BTN'(1) << gnt_idx) : '0;
  assign drops    = btn_pulse_i & pending_o & ~gnt_mask;

  always_comb begin
    ndrop = '0;
    for (int i = 0; i < N_BTN; i++)
      ndrop = ndrop + CNT_W'(drops[i]);
  end

  assign drop_sum  = SUM_W'(drop_cnt_o) + SUM_W'(ndrop);
  assign drop_next = (drop_sum > SUM_W'({DROP_W{1'b1}})) ? {DROP_W{1'b1}}
                                                         : drop_sum[DROP_W-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      rr          <= '0;
      evt_valid_o <= 1'b0;
      evt_idx_o   <= '0;
      pending_o   <= '0;
      drop_cnt_o  <= '0;
    end else begin
      pending_o  <= (pending_o & ~gnt_mask) | btn_pulse_i;
      drop_cnt_o <= drop_next;
      if (fire) begin
        state       <= HOLD;
        evt_valid_o <= 1'b1;
        evt_idx_o   <= gnt_idx;
        rr          <= (gnt_idx == IDX_W'(N_BTN - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (state == HOLD && evt_ready_i) begin
        state       <= IDLE;
        evt_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Bench for btn_event_arbiter: fixed vector table, hand-written corner cases,
// then randomized traffic against an event-level reference model.
module tb_btn_event_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] pulse = '0;
  logic         ready = 1'b0;
  logic         evt_valid;
  logic [1:0]   evt_idx;
  logic [N-1:0] pending;
  logic [7:0]   drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic         m_valid;
  int           m_idx;
  logic [N-1:0] m_pend;
  int           m_rr;
  int           m_drop;

  always #5 clk = ~clk;

  btn_event_arbiter #(.N_BTN(N), .IDX_W(2), .DROP_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .btn_pulse_i(pulse), .evt_ready_i(ready),
    .evt_valid_o(evt_valid), .evt_idx_o(evt_idx), .pending_o(pending),
    .drop_cnt_o(drop_cnt)
  );

  typedef struct {
    logic [N-1:0] p;
    logic         r;
    logic         ev;
    logic [1:0]   ei;
    logic [N-1:0] ep;
  } vec_t;

  vec_t tbl[17];

  task automatic model_reset();
    m_valid = 1'b0; m_idx = 0; m_pend = '0; m_rr = 0; m_drop = 0;
  endtask

  task automatic model_step(input logic [N-1:0] p, input logic r);
    int g;
    bit any;
    bit fire;
    any = (m_pend != '0);
    g = -1;
    for (int i = 0; i < N; i++)
      if (g < 0 && m_pend[(m_rr + i) % N]) g = (m_rr + i) % N;
    fire = any && (!m_valid || r);
    for (int k = 0; k < N; k++) begin
      if (p[k] && m_pend[k] && !(fire && g == k)) m_drop++;
      if (fire && g == k) m_pend[k] = 1'b0;
      if (p[k]) m_pend[k] = 1'b1;
    end
    if (m_drop > 255) m_drop = 255;
    if (fire) begin
      m_valid = 1'b1; m_idx = g; m_rr = (g + 1) % N;
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic cycle(input logic [N-1:0] p, input logic r);
    pulse = p; ready = r;
    @(posedge clk);
    model_step(p, r);
    #1;
  endtask

  task automatic check(input string name, input logic ev, input logic [1:0] ei,
                       input logic [N-1:0] ep, input int ed);
    vectors++;
    if (evt_valid !== ev || evt_idx !== ei || pending !== ep || drop_cnt !== 8'(ed)) begin
      miscompares++;
      $display("FAIL %s: got valid=%0b idx=%0d pend=%b drop=%0d, expected valid=%0b idx=%0d pend=%b drop=%0d",
               name, evt_valid, evt_idx, pending, drop_cnt, ev, ei, ep, ed);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; pulse = '0; ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    check("reset", 1'b0, 2'd0, 4'b0000, 0);
  endtask

  initial begin
    // {pulse, ready, expected valid, idx, pending} from a fresh reset
    tbl[0]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b1111};
    tbl[1]  = '{4'b0000, 1'b1, 1'b1, 2'd0, 4'b1110};
    tbl[2]  = '{4'b0000, 1'b1, 1'b1, 2'd1, 4'b1100};
    tbl[3]  = '{4'b0000, 1'b1, 1'b1, 2'd2, 4'b1000};
    tbl[4]  = '{4'b0000, 1'b1, 1'b1, 2'd3, 4'b0000};
    tbl[5]  = '{4'b0011, 1'b1, 1'b0, 2'd3, 4'b0011};
    tbl[6]  = '{4'b0000, 1'b1, 1'b1, 2'd0, 4'b0010};
    tbl[7]  = '{4'b0000, 1'b1, 1'b1, 2'd1, 4'b0000};
    tbl[8]  = '{4'b0001, 1'b1, 1'b0, 2'd1, 4'b0001};
    tbl[9]  = '{4'b0000, 1'b1, 1'b1, 2'd0, 4'b0000};
    tbl[10] = '{4'b1001, 1'b1, 1'b0, 2'd0, 4'b1001};
    tbl[11] = '{4'b0000, 1'b1, 1'b1, 2'd3, 4'b0001};
    tbl[12] = '{4'b0000, 1'b1, 1'b1, 2'd0, 4'b0000};
    tbl[13] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};
    tbl[14] = '{4'b0100, 1'b1, 1'b0, 2'd0, 4'b0100};
    tbl[15] = '{4'b0000, 1'b1, 1'b1, 2'd2, 4'b0000};
    tbl[16] = '{4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000};

    do_reset();
    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].p, tbl[i].r);
      check($sformatf("table[%0d]", i), tbl[i].ev, tbl[i].ei, tbl[i].ep, 0);
      $display("vec %0d: pulse=%b ready=%0b -> valid=%0b idx=%0d pend=%b",
               i, tbl[i].p, tbl[i].r, evt_valid, evt_idx, pending);
    end

    // backpressure: index 1 held while ready is low, then 1 and 3 back to back
    do_reset();
    cycle(4'b1010, 1'b0); check("bp_capture", 1'b0, 2'd0, 4'b1010, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(4'b0000, 1'b0); check("bp_hold", 1'b1, 2'd1, 4'b1000, 0);
    end
    cycle(4'b0000, 1'b1); check("bp_next", 1'b1, 2'd3, 4'b0000, 0);
    cycle(4'b0000, 1'b1); check("bp_idle", 1'b0, 2'd3, 4'b0000, 0);
    $display("backpressure sequence done");

    // re-press in the accept cycle, then saturation of the drop counter
    do_reset();
    cycle(4'b0001, 1'b0); check("drop_cap", 1'b0, 2'd0, 4'b0001, 0);
    cycle(4'b0000, 1'b0); check("drop_grant", 1'b1, 2'd0, 4'b0000, 0);
    cycle(4'b0001, 1'b0); check("drop_repend", 1'b1, 2'd0, 4'b0001, 0);
    cycle(4'b0001, 1'b1); check("accept_and_press", 1'b1, 2'd0, 4'b0001, 0);
    for (int n = 1; n <= 300; n++) begin
      cycle(4'b0001, 1'b0);
      check($sformatf("drop_%0d", n), 1'b1, 2'd0, 4'b0001, (n > 255) ? 255 : n);
    end
    cycle(4'b1111, 1'b0); check("drop_sat_multi", 1'b1, 2'd0, 4'b1111, 255);
    $display("drop sequence done, drop_cnt=%0d", drop_cnt);

    // asynchronous reset mid-handshake
    do_reset();
    cycle(4'b0000, 1'b0);
    cycle(4'b0111, 1'b0); check("rst_prep0", 1'b0, 2'd0, 4'b0111, 0);
    cycle(4'b0000, 1'b0); check("rst_prep1", 1'b1, 2'd0, 4'b0110, 0);
    #2 rst = 1'b1;
    #1 check("async_reset", 1'b0, 2'd0, 4'b0000, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0000, 1'b1); check("post_reset_quiet", 1'b0, 2'd0, 4'b0000, 0);
    end
    cycle(4'b0011, 1'b1); check("post_reset_cap", 1'b0, 2'd0, 4'b0011, 0);
    cycle(4'b0000, 1'b1); check("post_reset_rr0", 1'b1, 2'd0, 4'b0010, 0);
    cycle(4'b0000, 1'b1); check("post_reset_rr1", 1'b1, 2'd1, 4'b0000, 0);
    $display("reset sequence done");

    // randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] p;
      logic r;
      p = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      r = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      cycle(p, r);
      check($sformatf("rand[%0d]", i), m_valid, 2'(m_idx), m_pend, m_drop);
    end
    $display("random phase done, model drop=%0d", m_drop);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/btn_event_arbiter.md
# btn_event_arbiter

Collects single-cycle press pulses from up to N debounced push-buttons, latches each as a pending event, and issues them one at a time to a downstream consumer (counter/display/game FSM) over a valid/ready handshake. Round-robin arbitration keeps any button from starving the others. Presses that arrive while the same button's event is still pending are counted as drops. It sits between the per-button debouncers and the application logic.

## Interface
- N_BTN, 4, number of button inputs (2..16)
- IDX_W, 2, width of event index; must equal ceil(log2(N_BTN))
- DROP_W, 8, width of saturating drop counter
- clk_i  in  1  system clock; all state changes on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- btn_pulse_i  in  N_BTN  one-cycle press pulses from debouncers, bit k = button k
- evt_ready_i  in  1  consumer accepts the current event when high with evt_valid_o
- evt_valid_o  out  1  event index on evt_idx_o is valid
- evt_idx_o  out  IDX_W  index of granted button
- pending_o  out  N_BTN  latched, not-yet-issued events
- drop_cnt_o  out  DROP_W  saturating count of dropped presses

## Operation
- Reset (async, while rst_i high): evt_valid_o=0, evt_idx_o=0, pending_o=0, drop_cnt_o=0, round-robin pointer rr=0, FSM in IDLE. In-flight and pending events are discarded; no event is emitted on reset release.
- Pending capture: btn_pulse_i[k]=1 sets pending[k] at the next edge.
- Drop rule: btn_pulse_i[k]=1 while pending[k]=1 and pending[k] is not being granted that cycle -> press is dropped, pending[k] stays 1, drop_cnt increments.
- Multiple drops in one cycle: drop_cnt increases by the number of dropped bits, saturating at 2^DROP_W-1 with no wrap.
- Simultaneous grant and pulse on the same k: the grant clears the old event and the pulse sets a new one. pending[k] ends 1 and no drop is counted.
- Output stage FSM:
  - IDLE (evt_valid_o=0): if any pending bit is set, grant and go to HOLD.
  - HOLD (evt_valid_o=1): evt_idx_o is held stable until accepted.
    - On evt_valid_o&&evt_ready_i: if another pending bit is set, grant it in the same cycle and stay in HOLD (back-to-back). Otherwise go to IDLE.
- Grant: search pending from index rr upward, wrapping modulo N_BTN. The first set bit g is loaded into evt_idx_o, pending[g] is cleared, and rr becomes (g+1) mod N_BTN.
- Arbitration sees only the registered pending bits. A pulse arriving in the grant cycle is not eligible until the next cycle.
- evt_ready_i is ignored while evt_valid_o=0.

## Timing
- Latency: pulse high in cycle t -> pending set after edge t+1 -> evt_valid_o high after edge t+2 (2 cycles), assuming the output stage is IDLE.
- Throughput: 1 event per cycle while evt_ready_i is held high and events are pending.
- Backpressure: evt_valid_o and evt_idx_o must not change while evt_valid_o=1 and evt_ready_i=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset assertion mid-handshake forces evt_valid_o low immediately (asynchronous), regardless of evt_ready_i.

## Test plan
- Single press: pulse on bit 2 at cycle 10, ready=1 -> evt_valid_o high at cycle 12 with evt_idx_o=2 for exactly 1 cycle; pending_o returns to 0.
- Round-robin: pulse 4'b1111 in one cycle, ready=1 -> events 0,1,2,3 issued on consecutive cycles. Then pulse 4'b0011 -> indices 0,1 issued (rr wrapped to 0).
  - Variant: pulses 4'b1001 with rr=1 -> order 3 then 0.
- Backpressure: ready=0, pulses on bits 1 and 3 -> evt_idx_o=1 held for 20 cycles. Raise ready -> 1 is accepted, then 3 is issued on the next cycle.
- Drops and saturation: ready=0, pending[0] already set, 300 further pulses on bit 0 with DROP_W=8 -> drop_cnt_o=255 and no wrap. Pulse bit 0 exactly in the cycle its grant is accepted -> no drop, and a second event 0 follows.
- Reset mid-operation: pending=4'b0110, evt_valid_o=1. Assert rst_i between clock edges -> all outputs 0 immediately, rr=0. After release, no event appears until a new pulse arrives.
